// File: rtl/pipeline_ctrl_pkg.sv
// Shared CPU pipeline-control types: FSM state, halt cause and forwarding select
// encodings, consumed by the EX operand mux and debug logic.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_HALT     = 2'b10
  } ctrl_state_e;

  typedef enum logic [1:0] {
    HC_NONE    = 2'b00,
    HC_DEC_ERR = 2'b01,
    HC_MEM_TO  = 2'b10
  } halt_cause_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Register-file write port as seen by the hazard logic
  typedef struct packed {
    logic       we;
    logic [4:0] rd;
  } wr_port_t;

  localparam int NUM_SRC = 2;
  localparam int CNT_W   = 8;

endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// Operand forwarding select for one EX source register; the younger MEM result wins.
module fwd_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  wr_port_t   mem_wr,
  input  wr_port_t   wb_wr,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (mem_wr.we && mem_wr.rd != 5'd0 && mem_wr.rd == rs)
      sel = FWD_MEM;
    else if (wb_wr.we && wb_wr.rd != 5'd0 && wb_wr.rd == rs)
      sel = FWD_WB;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: forwarding, load-use/branch/memory stalls and flushes,
// and a RUN/MEM_WAIT/HALT FSM with dmem timeout and error halt.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1_ID,
  input  logic [4:0] rs2_ID,
  input  logic [4:0] rs1_EX,
  input  logic [4:0] rs2_EX,
  input  logic [4:0] rd_EX,
  input  logic       mem_read_EX,
  input  logic       reg_write_EX,
  input  logic [4:0] rd_MEM,
  input  logic       reg_write_MEM,
  input  logic [4:0] rd_WB,
  input  logic       reg_write_WB,
  input  logic       pc_src_EX,
  input  logic       dmem_req_MEM,
  input  logic       dmem_ack,
  input  logic       err_ID,
  input  logic       err_clr,
  output logic       stall_IF,
  output logic       stall_ID,
  output logic       stall_EX,
  output logic       stall_MEM,
  output logic       flush_ID,
  output logic       flush_EX,
  output logic       flush_WB,
  output logic [1:0] fwd_A_EX,
  output logic [1:0] fwd_B_EX,
  output logic       halted,
  output logic [1:0] halt_cause,
  output logic [1:0] state
);

  ctrl_state_e                     state_q;
  halt_cause_e                     cause_q;
  logic [CNT_W-1:0]                wait_cnt;
  logic [NUM_SRC-1:0][4:0]         rs_ex;
  logic [NUM_SRC-1:0][1:0]         fwd_sel;
  wr_port_t                        mem_wr, wb_wr;
  logic                            mem_stall, load_use;

  assign mem_wr = '{we: reg_write_MEM, rd: rd_MEM};
  assign wb_wr  = '{we: reg_write_WB,  rd: rd_WB};
  assign rs_ex  = {rs2_EX, rs1_EX};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    fwd_unit u_fwd (
      .rs     (rs_ex[g]),
      .mem_wr (mem_wr),
      .wb_wr  (wb_wr),
      .sel    (fwd_sel[g])
    );
  end

  assign mem_stall = dmem_req_MEM & ~dmem_ack;
  // reg_write_EX is implied by mem_read_EX for loads, so it does not gate load_use
  assign load_use  = mem_read_EX & (rd_EX != 5'd0) & ((rd_EX == rs1_ID) | (rd_EX == rs2_ID));

  assign fwd_A_EX   = rst ? FWD_RF : fwd_sel[0];
  assign fwd_B_EX   = rst ? FWD_RF : fwd_sel[1];
  assign state      = state_q;
  assign halt_cause = cause_q;

  // Stall/flush decode is combinational so an ack releases the pipe in its own cycle
  always_comb begin
    stall_IF  = 1'b0;
    stall_ID  = 1'b0;
    stall_EX  = 1'b0;
    stall_MEM = 1'b0;
    flush_ID  = 1'b0;
    flush_EX  = 1'b0;
    flush_WB  = 1'b0;
    if (rst) begin
      flush_ID = 1'b1;
      flush_EX = 1'b1;
      flush_WB = 1'b1;
    end else if (state_q == ST_HALT) begin
      if (err_clr) begin
        flush_ID = 1'b1;
        flush_EX = 1'b1;
      end else begin
        {stall_IF, stall_ID, stall_EX, stall_MEM} = 4'hf;
        flush_WB = 1'b1;
      end
    end else if (mem_stall) begin
      {stall_IF, stall_ID, stall_EX, stall_MEM} = 4'hf;
      flush_WB = 1'b1;
    end else if (pc_src_EX) begin
      flush_ID = 1'b1;
      flush_EX = 1'b1;
    end else if (load_use) begin
      stall_IF = 1'b1;
      stall_ID = 1'b1;
      flush_EX = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      cause_q  <= HC_NONE;
      wait_cnt <= '0;
      halted   <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_stall) begin
            state_q  <= ST_MEM_WAIT;
            wait_cnt <= 8'd1;
          end else if (err_ID) begin
            state_q <= ST_HALT;
            cause_q <= HC_DEC_ERR;
            halted  <= 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          // err_ID is ignored here: the decode stage is held and its contents stale
          if (!mem_stall) begin
            state_q  <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
            state_q <= ST_HALT;
            cause_q <= HC_MEM_TO;
            halted  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_HALT: begin
          if (err_clr) begin
            state_q  <= ST_RUN;
            cause_q  <= HC_NONE;
            wait_cnt <= '0;
            halted   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_RUN;
          halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule
